// File: rtl/uart_transmitter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transmitter_fifo
//  Description : CPU UART transmit path. Bytes queue in a small FIFO and are
//                serialized as 8N1 frames at a fixed baud rate.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter_fifo #(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       tx_busy
);

    localparam int c_symbol_edge_time = CPU_CLOCK_FREQ / BAUD_RATE;
    localparam int c_cnt_w  = (c_symbol_edge_time > 1) ? $clog2(c_symbol_edge_time) : 1;
    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_ptr_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(c_symbol_edge_time - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    // ------------------------------------------------------------------
    // FIFO storage and pointers (one extra MSB distinguishes full/empty)
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_push  = data_in_valid && !w_full;
    assign w_head  = r_mem[r_rd_ptr[c_addr_w-1:0]];

    assign data_in_ready = !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [c_cnt_w-1:0] w_baud_next;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic               r_serial_out;
    logic               w_serial_next;
    logic               w_baud_done;

    assign w_baud_done = (r_baud_cnt == c_baud_last);

    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud_cnt;
        w_bit_next    = r_bit_idx;
        w_shift_next  = r_shift;
        w_pop         = 1'b0;
        w_serial_next = 1'b1;

        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_baud_next  = '0;
                    w_state_next = c_st_start;
                end
            end
            c_st_start: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_state_next = c_st_data;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            c_st_data: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = c_st_stop;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            c_st_stop: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    // Chain straight into the next frame when a byte is waiting
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = c_st_start;
                    end else begin
                        w_state_next = c_st_idle;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase

        // Line level is registered from the upcoming state so it never glitches
        case (w_state_next)
            c_st_start: w_serial_next = 1'b0;
            c_st_data:  w_serial_next = w_shift_next[w_bit_next];
            default:    w_serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_baud_cnt   <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_serial_out <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_baud_cnt   <= w_baud_next;
            r_bit_idx    <= w_bit_next;
            r_shift      <= w_shift_next;
            r_serial_out <= w_serial_next;
        end
    end

    assign serial_out = r_serial_out;
    assign tx_busy    = (r_state != c_st_idle) || !w_empty;

endmodule
`default_nettype wire
